wb_arbiter2: RTL and testbench

Two-master, single-slave Wishbone arbiter that shares the 16-bit register-map/loop-back-FIFO slave between the host bridge (master 0) and an internal sequencer (master 1). It sits between the masters and the slave. Grants are round-robin and held for a whole bus cycle (CYC high), so classic and incrementing bursts are never split. All slave-side strobes are gated, so the non-granted master never reaches the slave.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_arb_wdog.sv | 31 +++
 rtl/wb_arbiter2.sv | 165 ++++++++++++++++
 tb/tb_wb_arbiter2.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes and the arbiter state encoding.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_arb_wdog.sv
// Grant watchdog: counts stalled strobe cycles while a master holds the bus
// and flags expiry once the count reaches TIMEOUT_CYCLES.
module wb_arb_wdog
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stall,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT_CYCLES));

    // Stall counter: cleared by ACK or when no grant is active, saturates at the limit
    always_ff @(posedge clk) begin
        if (rst || !active || ack) begin
            cnt <= '0;
        end else if (stall && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, single-slave round-robin Wishbone arbiter. Grants are held for a
// whole CYC so bursts are never split; the non-granted master is fully gated.
// Optional grant watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int unsigned DW             = 16,
    parameter int unsigned AW             = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [1:0]    m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [1:0]    m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [1:0]    s_sel_o,
    output logic [2:0]    s_cti_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,

    output logic [1:0]    gnt_o
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last;
    logic       timeout;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .active  (state != ARB_IDLE),
        .stall   (s_stb_o && !s_ack_i),
        .ack     (s_ack_i),
        .expired (timeout)
    );
`else
    // Without the watchdog a grant ends only on CYC low or reset; the limit
    // parameter is kept in the port list so both builds share one instance.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer: records the master whose grant just ended
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last <= 1'b1;
        end else if (state == ARB_GNT0 && state_nxt == ARB_IDLE) begin
            last <= 1'b0;
        end else if (state == ARB_GNT1 && state_nxt == ARB_IDLE) begin
            last <= 1'b1;
        end
    end

    // Next-state: arbitrate only from IDLE, release on CYC low or watchdog expiry
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!m0_cyc_i || timeout) begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc_i || timeout) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs: route the granted master to the slave, gate everything else
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = CTI_CLASSIC;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (state)
            ARB_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | timeout;
                gnt_o    = 2'b01;
            end
            ARB_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | timeout;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed testbench for wb_arbiter2 with a small register-file slave model.
// The watchdog scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [4:0]  m0_adr = '0;
    logic [15:0] m0_dat = '0;
    logic [1:0]  m0_sel = 2'b11;
    logic [2:0]  m0_cti = '0;
    logic [15:0] m0_rdat;
    logic        m0_ack, m0_err;

    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [4:0]  m1_adr = '0;
    logic [15:0] m1_dat = '0;
    logic [1:0]  m1_sel = 2'b11;
    logic [2:0]  m1_cti = '0;
    logic [15:0] m1_rdat;
    logic        m1_ack, m1_err;

    logic        s_cyc, s_stb, s_we;
    logic [4:0]  s_adr;
    logic [15:0] s_dat_w;
    logic [1:0]  s_sel;
    logic [2:0]  s_cti;
    logic [15:0] s_dat_r;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [1:0]  gnt;

    logic        stall = 1'b0;
    logic [15:0] mem [32];
    int          ack_cnt0 = 0;
    int          ack_cnt1 = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    wb_arbiter2 #(
        .DW(16),
        .AW(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_cti_o(s_cti),
        .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    // Slave model: registered ACK, continuous ACKs during incrementing bursts
    assign s_dat_r = mem[s_adr];
    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
        end else begin
            if (s_cyc && s_stb && s_we && s_ack) begin
                if (s_sel[0]) mem[s_adr][7:0]  <= s_dat_w[7:0];
                if (s_sel[1]) mem[s_adr][15:8] <= s_dat_w[15:8];
            end
            s_ack <= s_cyc && s_stb && !stall && !(s_ack && s_cti != CTI_INCR);
        end
    end

    // Acknowledge counters per master
    always @(negedge clk) begin
        ack_cnt0 <= ack_cnt0 + int'(m0_ack);
        ack_cnt1 <= ack_cnt1 + int'(m1_ack);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "testbench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_m(input int idx, input logic cyc, input logic we,
                           input logic [4:0] adr, input logic [15:0] dat, input logic [2:0] cti);
        if (idx == 0) begin
            m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_dat = dat; m0_cti = cti;
        end else begin
            m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_dat = dat; m1_cti = cti;
        end
    endtask

    task automatic drop_m(input int idx);
        drive_m(idx, 1'b0, 1'b0, 5'd0, 16'h0, CTI_CLASSIC);
    endtask

    // Wait for ACK on master idx, capture read data, then step past the ACK edge
    task automatic beat(input string tag, input int idx, output logic [15:0] rdat);
        logic seen;
        seen = 1'b0;
        rdat = '0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if ((idx == 0) ? m0_ack : m1_ack) begin
                seen = 1'b1;
                rdat = (idx == 0) ? m0_rdat : m1_rdat;
            end
        end
        check({tag, "_ack"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [15:0] rd;
    logic [1:0]  exp_gnt [4];
    int          snap0, snap1, winner;

    initial begin
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_s_cyc", 32'(s_cyc), 32'h0);
        check("rst_s_stb", 32'(s_stb), 32'h0);
        check("rst_s_adr", 32'(s_adr), 32'h0);
        check("rst_s_cti", 32'(s_cti), 32'h0);
        check("rst_acks", {28'h0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write then read-back by m0, no contention
        @(posedge clk); #1;
        snap1 = ack_cnt1;
        drive_m(0, 1'b1, 1'b1, 5'd3, 16'h1234, CTI_CLASSIC);
        @(negedge clk);
        check("t1_gnt_latency", 32'(gnt), 32'h0);
        check("t1_s_cyc_latency", 32'(s_cyc), 32'h0);
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_s_adr", 32'(s_adr), 32'h3);
        check("t1_s_dat", 32'(s_dat_w), 32'h1234);
        check("t1_s_we", 32'(s_we), 32'h1);
        beat("t1_wr", 0, rd);
        drop_m(0);
        @(posedge clk); #1;
        drive_m(0, 1'b1, 1'b0, 5'd3, 16'h0, CTI_CLASSIC);
        beat("t1_rd", 0, rd);
        check("t1_rdata", 32'(rd), 32'h1234);
        drop_m(0);
        @(posedge clk); #1;
        check("t1_no_m1_ack", 32'(ack_cnt1 - snap1), 32'h0);

        // Simultaneous request right after reset: m0 first, one idle cycle, then m1
        do_reset();
        drive_m(0, 1'b1, 1'b1, 5'd5, 16'hAAAA, CTI_CLASSIC);
        drive_m(1, 1'b1, 1'b1, 5'd6, 16'h5555, CTI_CLASSIC);
        @(negedge clk);
        check("t2_gnt_latency", 32'(gnt), 32'h0);
        @(negedge clk);
        check("t2_first", 32'(gnt), 32'h1);
        beat("t2_m0", 0, rd);
        drop_m(0);
        @(negedge clk);
        @(negedge clk);
        check("t2_idle_gap", 32'(gnt), 32'h0);
        @(negedge clk);
        check("t2_second", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        snap0 = ack_cnt0;
        beat("t2_m1", 1, rd);
        drop_m(1);
        @(posedge clk); #1;
        check("t2_no_m0_ack", 32'(ack_cnt0 - snap0), 32'h0);
        check("t2_mem5", 32'(mem[5]), 32'hAAAA);
        check("t2_mem6", 32'(mem[6]), 32'h5555);

        // Round-robin with both masters requesting continuously
        do_reset();
        drive_m(0, 1'b1, 1'b0, 5'd5, 16'h0, CTI_CLASSIC);
        drive_m(1, 1'b1, 1'b0, 5'd6, 16'h0, CTI_CLASSIC);
        for (int i = 0; i < 4; i++) begin
            wait_gnt($sformatf("t3_grant%0d", i), exp_gnt[i]);
            winner = (gnt == 2'b10) ? 1 : 0;
            @(posedge clk); #1;
            beat($sformatf("t3_beat%0d", i), winner, rd);
            drop_m(winner);
            @(posedge clk); #1;
            drive_m(winner, 1'b1, 1'b0, (winner == 0) ? 5'd5 : 5'd6, 16'h0, CTI_CLASSIC);
            @(negedge clk);
            check($sformatf("t3_idle%0d", i), 32'(gnt), 32'h0);
        end
        drop_m(0);
        drop_m(1);

        // 8-beat incrementing burst by m1, m0 requests at beat 2
        do_reset();
        snap0 = ack_cnt0;
        snap1 = ack_cnt1;
        drive_m(1, 1'b1, 1'b1, 5'h11, 16'hB000, CTI_INCR);
        wait_gnt("t4_gnt_m1", 2'b10);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            beat($sformatf("t4_beat%0d", k), 1, rd);
            if (k == 1) drive_m(0, 1'b1, 1'b0, 5'h13, 16'h0, CTI_CLASSIC);
            if (k < 7) begin
                drive_m(1, 1'b1, 1'b1, 5'(5'h11 + k + 1), 16'(16'hB000 + k + 1),
                        (k == 6) ? CTI_EOB : CTI_INCR);
            end else begin
                drop_m(1);
            end
        end
        check("t4_m1_acks", 32'(ack_cnt1 - snap1), 32'd8);
        check("t4_m0_acks", 32'(ack_cnt0 - snap0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t4_idle_gap", 32'(gnt), 32'h0);
        @(negedge clk);
        check("t4_gnt_m0", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        beat("t4_m0_rd", 0, rd);
        check("t4_burst_data", 32'(rd), 32'hB002);
        drop_m(0);
        check("t4_mem18", 32'(mem[5'h18]), 32'hB007);

        // Reset asserted in the middle of an m0 burst
        @(posedge clk); #1;
        drive_m(0, 1'b1, 1'b1, 5'd1, 16'hC000, CTI_INCR);
        wait_gnt("t5_gnt", 2'b01);
        @(posedge clk); #1;
        beat("t5_beat0", 0, rd);
        beat("t5_beat1", 0, rd);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_s_cyc", 32'(s_cyc), 32'h0);
        check("t5_rst_m0_ack", 32'(m0_ack), 32'h0);
        drop_m(0);
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never acknowledges, ERR after four stalled cycles
        do_reset();
        stall = 1'b1;
        drive_m(0, 1'b1, 1'b0, 5'd2, 16'h0, CTI_CLASSIC);
        @(negedge clk);
        check("t6_gnt_latency", 32'(gnt), 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("t6_err_c%0d", c), 32'(m0_err), (c == 5) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        drop_m(0);
        stall = 1'b0;
        @(negedge clk);
        check("t6_err_pulse_end", 32'(m0_err), 32'h0);
        check("t6_idle_gnt", 32'(gnt), 32'h0);
        check("t6_idle_s_cyc", 32'(s_cyc), 32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
